// File: rtl/conv_output_collector_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : conv_output_collector_pkg                               |
// | Purpose  : Shared FSM encoding, requantization saturation limits   |
// |            and expected-sample-count helper for the collector.     |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package conv_output_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // Saturation window of the 16-bit signed output
  localparam logic signed [31:0] SAT_MAX   = 32'sd32767;
  localparam logic signed [31:0] SAT_MIN   = -32'sd32768;
  localparam logic        [15:0] SAT_MAX_Q = 16'h7fff;
  localparam logic        [15:0] SAT_MIN_Q = 16'h8000;

  // Number of pooled outputs per frame: ((n-k+1)/p)^2
  function automatic int calc_exp_cnt(input int n, input int k, input int p);
    int side;
    side = (n - k + 1) / p;
    return side * side;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_output_collector_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sync_fifo                                               |
// | Purpose  : Single-clock FIFO. A push into a full FIFO is taken     |
// |            only when a pop happens in the same cycle. No           |
// |            write-to-read bypass: a word is visible the cycle after |
// |            it is written. Head reads 0 while empty.                |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Extra MSB separates the full and empty cases of equal indices
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update, wrapping naturally modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/conv_output_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : conv_output_collector                                   |
// | Purpose  : Collects accelerator results for one frame, requantizes |
// |            them (>>> SHIFT, saturate to 16 bits), buffers them in  |
// |            a FIFO and drains them over a valid/ready interface,    |
// |            tagging the EXP_CNT-th word with out_last.              |
// | Options  : CONV_COLLECT_RELU_EN - clamp negative values to 0.      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module conv_output_collector
  import conv_output_collector_pkg::*;
#(
  parameter int N     = 10,
  parameter int K     = 3,
  parameter int P     = 2,
  parameter int SHIFT = 8,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        global_rst,
  input  logic        ce,
  input  logic [31:0] acc_data,
  input  logic        acc_valid,
  input  logic        acc_end,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_done,
  output logic        count_err,
  output logic        overflow
);

  localparam int                EXP_CNT   = calc_exp_cnt(N, K, P);
  localparam int                CNT_W     = $clog2(EXP_CNT + 1);
  localparam logic [CNT_W-1:0]  EXP_CNT_W = CNT_W'(EXP_CNT);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              excess;
  logic              excess_now;
  logic              accept;
  logic              cnt_at_max;
  logic              sample_last;
  logic              end_err;
  logic              drain_exit;

  logic              pipe_valid;
  logic [15:0]       pipe_data;
  logic              pipe_last;
  logic signed [31:0] shifted;
  logic [15:0]       requant;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [16:0]       fifo_rdata;

  // Samples are taken in IDLE (starting a frame) and COLLECT only
  assign accept      = ce & acc_valid & (state != ST_DRAIN);
  assign cnt_at_max  = (cnt == EXP_CNT_W);
  assign cnt_inc     = (accept && !cnt_at_max) ? cnt + CNT_W'(1) : cnt;
  assign sample_last = accept && !cnt_at_max && (cnt + CNT_W'(1) == EXP_CNT_W);
  assign excess_now  = excess | (accept & cnt_at_max);
  assign end_err     = excess_now | (cnt_inc != EXP_CNT_W);

  assign fifo_push   = pipe_valid & ce;
  assign fifo_pop    = out_ready & ~fifo_empty;
  assign out_valid   = ~fifo_empty;
  assign out_data    = fifo_rdata[15:0];
  assign out_last    = fifo_rdata[16];

  // The frame is drained once its last word leaves, or nothing is left
  // anywhere (FIFO empty and no word still in the pipeline register)
  assign drain_exit  = (fifo_pop & fifo_rdata[16]) | (fifo_empty & ~pipe_valid);

  // Requantize: arithmetic shift, optional ReLU, then 16-bit saturation
  always_comb begin
    shifted = $signed(acc_data) >>> SHIFT;
`ifdef CONV_COLLECT_RELU_EN
    if (shifted < 0) shifted = '0;
`endif
    if (shifted > SAT_MAX)      requant = SAT_MAX_Q;
    else if (shifted < SAT_MIN) requant = SAT_MIN_Q;
    else                        requant = shifted[15:0];
  end

  // Next-state logic; the FSM only advances while ce is high
  always_comb begin
    state_nxt = state;
    if (ce) begin
      case (state)
        ST_IDLE:    if (acc_valid)  state_nxt = ST_COLLECT;
        ST_COLLECT: if (acc_end)    state_nxt = ST_DRAIN;
        ST_DRAIN:   if (drain_exit) state_nxt = ST_IDLE;
        default:                    state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (global_rst) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Frame sample counter, cleared when the frame returns to IDLE
  always_ff @(posedge clk) begin
    if (global_rst || (ce && state == ST_DRAIN && drain_exit)) begin
      cnt    <= '0;
      excess <= 1'b0;
    end else if (accept) begin
      cnt    <= cnt_inc;
      excess <= excess_now;
    end
  end

  // One-stage requantization pipeline, frozen while ce is low
  always_ff @(posedge clk) begin
    if (global_rst) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
      pipe_last  <= 1'b0;
    end else if (ce) begin
      pipe_valid <= accept;
      pipe_data  <= requant;
      pipe_last  <= sample_last;
    end
  end

  // Status flags: sticky errors and the end-of-frame pulse
  always_ff @(posedge clk) begin
    if (global_rst) begin
      count_err  <= 1'b0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= ce & (state == ST_DRAIN) & drain_exit;
      if (ce && state == ST_COLLECT && acc_end && end_err)
        count_err <= 1'b1;
      if ((ce && acc_valid && state == ST_DRAIN) ||
          (fifo_push && fifo_full && !fifo_pop))
        overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (17),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (global_rst),
    .push      (fifo_push),
    .push_data ({pipe_last, pipe_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_conv_output_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_conv_output_collector                                |
// | Purpose  : Self-checking bench for conv_output_collector with a    |
// |            queue-based reference model. Honors                     |
// |            CONV_COLLECT_RELU_EN in its expectations.               |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_conv_output_collector;

  localparam int EXP   = 16;
  localparam int DEPTH = 16;
  localparam int SHIFT = 8;

  typedef struct packed {
    logic        l;
    logic [15:0] d;
  } word_t;

  logic        clk = 1'b0;
  logic        global_rst;
  logic        ce;
  logic [31:0] acc_data;
  logic        acc_valid;
  logic        acc_end;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        frame_done;
  logic        count_err;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  word_t mq[$];
  int    m_phase;   // 0 idle, 1 collecting, 2 draining
  int    m_cnt;
  bit    m_excess;
  bit    m_pv;
  word_t m_pw;
  bit    m_fd, m_err, m_ovf;
  bit    chk_en = 1'b0;

  logic [16:0] got[$];
  int          fd_count = 0;

  conv_output_collector dut (
    .clk        (clk),
    .global_rst (global_rst),
    .ce         (ce),
    .acc_data   (acc_data),
    .acc_valid  (acc_valid),
    .acc_end    (acc_end),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_done (frame_done),
    .count_err  (count_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Floor division by 2^SHIFT, optional ReLU, clamp to int16
  function automatic logic [15:0] ref_q(input logic [31:0] a);
    longint v, d, q;
    v = longint'($signed(a));
    d = longint'(1) << SHIFT;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
`ifdef CONV_COLLECT_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  // Reference model: frame bookkeeping, pipeline delay and FIFO contents
  always @(posedge clk) begin : ref_model
    int    sz, old_phase;
    bit    pop, pop_last, acc, do_push;
    word_t old_pw, nw;
    if (global_rst) begin
      mq.delete();
      m_phase = 0; m_cnt = 0; m_excess = 0; m_pv = 0;
      m_fd = 0; m_err = 0; m_ovf = 0; chk_en = 1'b1;
    end else begin
      sz        = mq.size();
      pop       = (sz > 0) && out_ready;
      pop_last  = pop && mq[0].l;
      old_phase = m_phase;
      old_pw    = m_pw;
      do_push   = 0;
      acc       = 0;
      nw        = '0;
      m_fd      = 0;
      if (ce) begin
        if (m_pv) begin
          if (sz < DEPTH || pop) do_push = 1;
          else                   m_ovf   = 1;
        end
        if (old_phase == 0 && acc_valid) begin
          acc = 1; m_phase = 1;
        end else if (old_phase == 1) begin
          acc = acc_valid;
        end else if (old_phase == 2) begin
          if (acc_valid) m_ovf = 1;
          if (pop_last || (sz == 0 && !m_pv)) begin
            m_phase = 0; m_cnt = 0; m_excess = 0; m_fd = 1;
          end
        end
        if (acc) begin
          nw.d = ref_q(acc_data);
          if (m_cnt < EXP) begin
            m_cnt++;
            nw.l = (m_cnt == EXP);
          end else begin
            m_excess = 1;
          end
        end
        if (old_phase == 1 && acc_end) begin
          if (m_excess || m_cnt != EXP) m_err = 1;
          m_phase = 2;
        end
        m_pv = acc;
        m_pw = nw;
      end
      if (pop)     void'(mq.pop_front());
      if (do_push) mq.push_back(old_pw);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the clock edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid",  {31'd0, out_valid},  {31'd0, mq.size() > 0});
      check("out_data",   {16'd0, out_data},   {16'd0, (mq.size() > 0) ? mq[0].d : 16'h0});
      check("out_last",   {31'd0, out_last},   {31'd0, (mq.size() > 0) ? mq[0].l : 1'b0});
      check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      check("count_err",  {31'd0, count_err},  {31'd0, m_err});
      check("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back({out_last, out_data});
      if (frame_done === 1'b1) fd_count++;
    end
  end

  task automatic rst_pulse();
    @(negedge clk);
    global_rst = 1'b1; acc_valid = 1'b0; acc_end = 1'b0; ce = 1'b1;
    @(negedge clk);
    global_rst = 1'b0;
  endtask

  // Feed n accepted samples. kind: 0 ramp i<<8, 1 random, 2 saturation pair then random.
  task automatic send_frame(input int n, input bit rnd, input int kind, input bit with_end);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      ce        = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      acc_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rnd) out_ready = $urandom_range(0, 1) != 0;
      case (kind)
        0:       acc_data = 32'(sent) << 8;
        2:       acc_data = (sent == 0) ? 32'h7FFF_FFFF : (sent == 1) ? 32'h8000_0000 : $urandom;
        default: acc_data = $urandom;
      endcase
      acc_end = acc_valid && ce && with_end && (sent == n - 1);
      if (acc_valid && ce) sent++;
    end
    if (sent < n) check("send_timeout", 32'(sent), 32'(n));
    @(negedge clk);
    acc_valid = 1'b0; acc_end = 1'b0; ce = 1'b1;
  endtask

  task automatic wait_idle();
    int k = 0;
    out_ready = 1'b1;
    while (!(m_phase == 0 && mq.size() == 0 && !m_pv) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("drain_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    global_rst = 1'b1; ce = 1'b0; acc_valid = 1'b0; acc_end = 1'b0;
    acc_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid",  {31'd0, out_valid},  0);
    check("rst_out_data",   {16'd0, out_data},   0);
    check("rst_out_last",   {31'd0, out_last},   0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    check("rst_count_err",  {31'd0, count_err},  0);
    check("rst_overflow",   {31'd0, overflow},   0);
    global_rst = 1'b0; ce = 1'b1;

    // Ramp frame: words 0..15, last on word 15, one frame_done
    got.delete(); fd_count = 0;
    send_frame(16, 0, 0, 1);
    wait_idle();
    check("ramp_words", 32'(got.size()), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      check("ramp_word", {15'd0, got[i]}, {15'd0, (i == 15), 16'(i)});
    check("ramp_fd", 32'(fd_count), 1);
    check("ramp_flags", {30'd0, count_err, overflow}, 0);

    // Saturation at both ends
    got.delete();
    send_frame(16, 0, 2, 1);
    wait_idle();
    check("sat_words", 32'(got.size()), 16);
    if (got.size() >= 2) begin
      check("sat_pos", {16'd0, got[0][15:0]}, 32'h7FFF);
`ifdef CONV_COLLECT_RELU_EN
      check("sat_neg", {16'd0, got[1][15:0]}, 32'h0000);
`else
      check("sat_neg", {16'd0, got[1][15:0]}, 32'h8000);
`endif
    end

    // Backpressure: 20 samples into a 16-entry FIFO with ready low
    @(negedge clk); out_ready = 1'b0;
    got.delete();
    send_frame(20, 0, 1, 1);
    repeat (8) @(negedge clk);
    check("bp_overflow", {31'd0, overflow}, 1);
    check("bp_valid", {31'd0, out_valid}, 1);
    wait_idle();
    check("bp_words", 32'(got.size()), 16);
    check("bp_count_err", {31'd0, count_err}, 1);
    rst_pulse();

    // Short frame: count error, no last, frame_done after drain
    got.delete(); fd_count = 0;
    send_frame(12, 0, 1, 1);
    wait_idle();
    check("short_words", 32'(got.size()), 12);
    for (int i = 0; i < got.size(); i++)
      check("short_no_last", {31'd0, got[i][16]}, 0);
    check("short_count_err", {31'd0, count_err}, 1);
    check("short_fd", 32'(fd_count), 1);

    // Reset mid-frame, then a clean frame with no stale words
    send_frame(8, 0, 1, 0);
    rst_pulse();
    got.delete(); fd_count = 0;
    send_frame(16, 0, 0, 1);
    wait_idle();
    check("clean_words", 32'(got.size()), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      check("clean_word", {16'd0, got[i][15:0]}, 32'(i));
    check("clean_flags", {30'd0, count_err, overflow}, 0);
    check("clean_fd", 32'(fd_count), 1);

    // Random frames with ce gaps and random backpressure
    for (int f = 0; f < 20; f++) begin
      send_frame($urandom_range(14, 18), 1, 1, 1);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
